// File: rtl/ddi_phase_sequencer_pkg.sv
// Shared encodings for the DDI phase sequencer: controller state values driven on the state port.
package ddi_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_ALL_RED = 2'd0,
    SEQ_GREEN   = 2'd1,
    SEQ_YELLOW  = 2'd2,
    SEQ_MAINT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ddi_phase_sequencer_if.sv
// Control/status bundle between the phase sequencer and its host (timing config, requests, lamps).
interface ddi_phase_sequencer_if
  import ddi_phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 16,
  parameter int PH_W       = $clog2(NUM_PHASES)
);
  logic                        tick;
  logic                        maintenance;
  logic [NUM_PHASES-1:0]       phase_req;
  logic [NUM_PHASES*CNT_W-1:0] green_time;
  logic [CNT_W-1:0]            yellow_time;
  logic [CNT_W-1:0]            allred_time;
  logic [1:0]                  state;
  logic [PH_W-1:0]             active_phase;
  logic [NUM_PHASES-1:0]       lamp_red;
  logic [NUM_PHASES-1:0]       lamp_yellow;
  logic [NUM_PHASES-1:0]       lamp_green;
  logic                        phase_start;

  modport master (
    output tick, maintenance, phase_req, green_time, yellow_time, allred_time,
    input  state, active_phase, lamp_red, lamp_yellow, lamp_green, phase_start
  );

  modport slave (
    input  tick, maintenance, phase_req, green_time, yellow_time, allred_time,
    output state, active_phase, lamp_red, lamp_yellow, lamp_green, phase_start
  );
endinterface

// File: rtl/ddi_phase_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first pending phase after 'last', wrapping by explicit compare.
module ddi_rr_arbiter
  import ddi_phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] pending,
  input  logic [PH_W-1:0]       last,
  output logic [PH_W-1:0]       sel,
  output logic                  valid
);
  localparam logic [PH_W-1:0] LAST_IDX = PH_W'(NUM_PHASES - 1);

  logic [PH_W-1:0] idx;
  logic            found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = last;
    for (int k = 0; k < NUM_PHASES; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + PH_W'(1);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign valid = |pending;

endmodule

// File: rtl/ddi_phase_sequencer.sv
// Signal-phase sequencer: tick-timed GREEN/YELLOW/ALL_RED cycling with round-robin request service.
//   state       | meaning
//   SEQ_ALL_RED | clearance, every phase red; picks the next phase on expiry
//   SEQ_GREEN   | active_phase green, others red
//   SEQ_YELLOW  | active_phase yellow, others red
//   SEQ_MAINT   | all reds flash together while maintenance is held
module ddi_phase_sequencer
  import ddi_phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int PH_W        = $clog2(NUM_PHASES),
  parameter int CNT_W       = 16,
  parameter int RESET_CLEAR = 4,
  parameter int FLASH_TICKS = 8
) (
  input logic                 clk,
  input logic                 rst,
  ddi_phase_sequencer_if.slave bus
);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(RESET_CLEAR - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TICKS - 1);

  seq_state_e            state_q;
  logic [CNT_W-1:0]      timer_q;
  logic [CNT_W-1:0]      flash_cnt_q;
  logic [PH_W-1:0]       active_q;
  logic [NUM_PHASES-1:0] pending_q;
  logic                  flash_q;
  logic                  maint_meta_q;
  logic                  maint_s_q;
  logic [NUM_PHASES-1:0] red_q;
  logic [NUM_PHASES-1:0] yellow_q;
  logic [NUM_PHASES-1:0] green_q;
  logic                  start_q;

  logic [PH_W-1:0]       arb_sel;
  logic                  arb_valid;
  logic [PH_W-1:0]       next_phase;
  logic [PH_W-1:0]       green_sel;
  logic [CNT_W-1:0]      green_arr [NUM_PHASES];

  function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  function automatic logic [NUM_PHASES-1:0] onehot(input logic [PH_W-1:0] p);
    logic [NUM_PHASES-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_green
    assign green_arr[i] = bus.green_time[i*CNT_W +: CNT_W];
  end

  ddi_rr_arbiter #(
    .NUM_PHASES(NUM_PHASES),
    .PH_W      (PH_W)
  ) u_arb (
    .pending(pending_q),
    .last   (active_q),
    .sel    (arb_sel),
    .valid  (arb_valid)
  );

  assign next_phase = (active_q == LAST_PHASE) ? '0 : active_q + PH_W'(1);
  assign green_sel  = arb_valid ? arb_sel : next_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEQ_ALL_RED;
      timer_q      <= CLEAR_LOAD;
      flash_cnt_q  <= '0;
      active_q     <= LAST_PHASE;
      pending_q    <= '0;
      flash_q      <= 1'b0;
      maint_meta_q <= 1'b0;
      maint_s_q    <= 1'b0;
      red_q        <= '1;
      yellow_q     <= '0;
      green_q      <= '0;
      start_q      <= 1'b0;
    end else begin
      maint_meta_q <= bus.maintenance;
      maint_s_q    <= maint_meta_q;
      pending_q    <= pending_q | bus.phase_req;
      start_q      <= 1'b0;
      if (maint_s_q) begin
        yellow_q <= '0;
        green_q  <= '0;
        if (state_q != SEQ_MAINT) begin
          state_q     <= SEQ_MAINT;
          flash_q     <= 1'b1;
          flash_cnt_q <= FLASH_LOAD;
          red_q       <= '1;
        end else if (bus.tick) begin
          if (flash_cnt_q == '0) begin
            flash_q     <= ~flash_q;
            flash_cnt_q <= FLASH_LOAD;
            red_q       <= {NUM_PHASES{~flash_q}};
          end else begin
            flash_cnt_q <= flash_cnt_q - CNT_W'(1);
          end
        end
      end else if (state_q == SEQ_MAINT) begin
        // Restart from phase 0 after maintenance; pending requests deliberately survive.
        state_q  <= SEQ_ALL_RED;
        timer_q  <= load_of(bus.allred_time);
        active_q <= LAST_PHASE;
        flash_q  <= 1'b0;
        red_q    <= '1;
        yellow_q <= '0;
        green_q  <= '0;
      end else if (bus.tick) begin
        if (timer_q != '0) begin
          timer_q <= timer_q - CNT_W'(1);
        end else begin
          case (state_q)
            SEQ_GREEN: begin
              state_q  <= SEQ_YELLOW;
              timer_q  <= load_of(bus.yellow_time);
              red_q    <= ~onehot(active_q);
              yellow_q <= onehot(active_q);
              green_q  <= '0;
            end
            SEQ_YELLOW: begin
              state_q  <= SEQ_ALL_RED;
              timer_q  <= load_of(bus.allred_time);
              red_q    <= '1;
              yellow_q <= '0;
              green_q  <= '0;
            end
            SEQ_ALL_RED: begin
              state_q              <= SEQ_GREEN;
              active_q             <= green_sel;
              timer_q              <= load_of(green_arr[green_sel]);
              red_q                <= ~onehot(green_sel);
              yellow_q             <= '0;
              green_q              <= onehot(green_sel);
              start_q              <= 1'b1;
              // A request arriving on the entry clk keeps its bit set for the next round.
              pending_q[green_sel] <= bus.phase_req[green_sel];
            end
            default: begin
              state_q  <= SEQ_MAINT;
              red_q    <= '1;
              yellow_q <= '0;
              green_q  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.active_phase = active_q;
  assign bus.lamp_red     = red_q;
  assign bus.lamp_yellow  = yellow_q;
  assign bus.lamp_green   = green_q;
  assign bus.phase_start  = start_q;

endmodule

// File: tb/tb_ddi_phase_sequencer.sv
// Scoreboard bench for ddi_phase_sequencer: directed scenarios plus randomized traffic vs a tick-count model.
module tb_ddi_phase_sequencer;
  import ddi_phase_sequencer_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int PW = 2;
  localparam int RC = 4;
  localparam int FT = 8;

  typedef struct packed {
    logic [1:0]    st;
    logic [PW-1:0] ph;
    logic [N-1:0]  r;
    logic [N-1:0]  y;
    logic [N-1:0]  g;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ddi_phase_sequencer_if #(.NUM_PHASES(N), .CNT_W(CW), .PH_W(PW)) bus ();

  ddi_phase_sequencer #(
    .NUM_PHASES(N), .PH_W(PW), .CNT_W(CW), .RESET_CLEAR(RC), .FLASH_TICKS(FT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t exp_q[$];
  int   start_q[$];

  // model: stage number, ticks left in stage (>=1), served phase, pending mask
  int         m_st, m_left, m_cur, m_flash_left;
  bit         m_flash, m_m1, m_ms;
  bit [N-1:0] m_pend;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL timeout %s: event not seen within its cycle budget (t=%0t)", name, $time);
  endtask

  function automatic int dur(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic obs_t expect_obs();
    obs_t o;
    o.st = 2'(m_st);
    o.ph = PW'(m_cur);
    o.r  = '1;
    o.y  = '0;
    o.g  = '0;
    case (m_st)
      1: begin o.g = N'(1) << m_cur; o.r = ~o.g; end
      2: begin o.y = N'(1) << m_cur; o.r = ~o.y; end
      3: o.r = m_flash ? '1 : '0;
      default: ;
    endcase
    return o;
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = RC; m_cur = N - 1; m_pend = '0;
    m_flash = 0; m_flash_left = FT; m_m1 = 0; m_ms = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] req;
    int pick, p;
    req = bus.phase_req;
    if (m_ms) begin
      if (m_st != 3) begin
        m_st = 3; m_flash = 1; m_flash_left = FT;
      end else if (bus.tick) begin
        m_flash_left--;
        if (m_flash_left == 0) begin m_flash = !m_flash; m_flash_left = FT; end
      end
    end else if (m_st == 3) begin
      m_st = 0; m_left = dur(int'(bus.allred_time)); m_cur = N - 1;
    end else if (bus.tick) begin
      if (m_left > 1) m_left--;
      else if (m_st == 1) begin m_st = 2; m_left = dur(int'(bus.yellow_time)); end
      else if (m_st == 2) begin m_st = 0; m_left = dur(int'(bus.allred_time)); end
      else begin
        pick = (m_cur + 1) % N;
        for (int k = N; k >= 1; k--) begin
          p = (m_cur + k) % N;
          if (((m_pend >> p) & N'(1)) != '0) pick = p;
        end
        m_cur  = pick;
        m_st   = 1;
        m_left = dur(int'(CW'(bus.green_time >> (pick * CW))));
        m_pend = m_pend & ~(N'(1) << pick);
        start_q.push_back(pick);
      end
    end
    m_pend = m_pend | req;
    m_ms   = m_m1;
    m_m1   = bus.maintenance;
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step();
    exp_q.push_back(expect_obs());
  end

  always @(posedge rst) begin
    model_reset();
    exp_q.delete();
    start_q.delete();
  end

  // monitor: compares whatever the DUT presents against queued expectations
  always @(negedge clk) begin
    obs_t a, e;
    a = {bus.state, bus.active_phase, bus.lamp_red, bus.lamp_yellow, bus.lamp_green};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs{state,phase,red,yel,grn}", longint'(a), longint'(e));
    end
    if (bus.phase_start) begin
      if (start_q.size() == 0) check("phase_start_unexpected", 1, 0);
      else check("phase_start_phase", bus.active_phase, start_q.pop_front());
    end else if (start_q.size() != 0) begin
      check("phase_start_missing", 0, 1);
      start_q.delete();
    end
    if (bus.state != 2'd3) begin
      check("one_lamp_per_phase",
            {(a.r & a.y) | (a.r & a.g) | (a.y & a.g), ~(a.r | a.y | a.g)}, 0);
      check("single_green", $countones(a.g) <= 1, 1);
    end
  end

  task automatic set_green(input int g0, input int g1, input int g2, input int g3);
    bus.green_time = {CW'(g3), CW'(g2), CW'(g1), CW'(g0)};
  endtask

  task automatic wait_for(input int s, input int p, input int budget, input string name);
    int n;
    n = 0;
    while (!(bus.state == 2'(s) && (p < 0 || bus.active_phase == PW'(p))) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout_fail(name);
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.phase_start && n < budget);
    if (!bus.phase_start) timeout_fail("phase_start");
  endtask

  task automatic run_random(input int cycles);
    int tick_mode, maint_left;
    tick_mode  = 0;
    maint_left = $urandom_range(50, 150);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (c % 250 == 0) tick_mode = $urandom_range(0, 2);
      if (c % 150 == 0) begin
        set_green($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
        bus.yellow_time = CW'($urandom_range(0, 3));
        bus.allred_time = CW'($urandom_range(0, 3));
      end
      case (tick_mode)
        0:       bus.tick = 1'b1;
        1:       bus.tick = (c % 4 == 0);
        default: bus.tick = 1'($urandom_range(0, 1));
      endcase
      bus.phase_req = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
      if (maint_left == 0) begin
        bus.maintenance = ~bus.maintenance;
        maint_left = bus.maintenance ? $urandom_range(10, 40) : $urandom_range(80, 250);
      end else begin
        maint_left--;
      end
    end
  endtask

  initial begin
    int n, g;
    bus.tick = 1'b1; bus.maintenance = 1'b0; bus.phase_req = '0;
    set_green(3, 3, 3, 3);
    bus.yellow_time = CW'(2);
    bus.allred_time = CW'(1);
    repeat (3) @(negedge clk);
    check("reset_state", bus.state, 0);
    check("reset_phase", bus.active_phase, N - 1);
    check("reset_red", bus.lamp_red, 4'hF);
    rst = 1'b0;

    // fixed-time order with no requests: 4-tick clear then 6-clk phases
    wait_start(20, n);
    check("first_start_latency", n, 4);
    check("first_phase", bus.active_phase, 0);
    for (int i = 1; i <= 4; i++) begin
      wait_start(20, n);
      check("start_spacing", n, 6);
      check("fixed_order_phase", bus.active_phase, i % N);
    end

    // request for phase 2 during phase 0 green skips phase 1
    bus.phase_req = 4'b0100;
    @(negedge clk);
    bus.phase_req = '0;
    wait_start(20, n);
    check("rr_skip_to_ph2", bus.active_phase, 2);
    wait_start(20, n);
    check("rr_then_ph3", bus.active_phase, 3);

    // maintenance mid phase-1 green
    wait_for(1, 1, 80, "ph1_green");
    bus.maintenance = 1'b1;
    repeat (3) @(negedge clk);
    check("maint_entry_state", bus.state, 3);
    check("maint_green_off", bus.lamp_green, 0);
    check("maint_flash_on", bus.lamp_red, 4'hF);
    repeat (8) @(negedge clk);
    check("maint_flash_off", bus.lamp_red, 0);
    repeat (8) @(negedge clk);
    check("maint_flash_on_again", bus.lamp_red, 4'hF);
    bus.maintenance = 1'b0;
    wait_start(20, n);
    check("maint_exit_phase", bus.active_phase, 0);

    // zero green duration on phase 1 with a 1-in-4 tick
    set_green(3, 0, 3, 3);
    n = 0;
    do begin
      @(negedge clk);
      bus.tick = (n % 4 == 0);
      n++;
    end while (!(bus.phase_start && bus.active_phase == 1) && n < 400);
    if (n >= 400) timeout_fail("ph1_start_slow_tick");
    g = 0;
    do begin
      @(negedge clk);
      bus.tick = (n % 4 == 0);
      n++;
      g++;
    end while (bus.state == 2'd1 && g < 40);
    check("ph1_zero_green_clks", g, 4);
    bus.tick = 1'b1;

    run_random(1500);

    // async reset mid-yellow with a request just latched
    bus.tick = 1'b1; bus.maintenance = 1'b0; bus.phase_req = '0;
    set_green(3, 3, 3, 3);
    bus.yellow_time = CW'(3);
    bus.allred_time = CW'(1);
    wait_for(2, -1, 200, "yellow_before_reset");
    bus.phase_req = 4'b0100;
    @(posedge clk);
    #2 rst = 1'b1;
    bus.phase_req = '0;
    #1;
    check("async_rst_state", bus.state, 0);
    check("async_rst_phase", bus.active_phase, N - 1);
    check("async_rst_red", bus.lamp_red, 4'hF);
    check("async_rst_yellow", bus.lamp_yellow, 0);
    check("async_rst_green", bus.lamp_green, 0);
    check("async_rst_start", bus.phase_start, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_start(20, n);
    check("post_reset_clear_clks", n, 4);
    check("post_reset_phase", bus.active_phase, 0);
    wait_start(20, n);
    check("post_reset_pending_cleared", bus.active_phase, 1);

    run_random(400);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
